serial_ripple_subtractor: RTL and testbench

- Sequential bit-serial subtractor: computes diff = a - b - bin, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow flip-flop.
- It is the inverse operation of the team's combinational ripple-carry adder.
- It sits beside the adder in the arithmetic library and serves area-constrained paths that can tolerate WIDTH+1 cycles of latency.
- Operands are captured on a start/busy/done handshake.

---
 rtl/serial_ripple_subtractor.sv | 109 ++++++++++
 tb/tb_serial_ripple_subtractor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), start/busy/done handshake,
//        a, b, bin operands in; diff, bout (unsigned borrow), ovf (signed) out.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 low result bits; the last bit joins them
    // directly on the way into diff.
    logic [WIDTH-2:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             d;
    logic             brw_next;
    logic [WIDTH-1:0] sh;

    assign d        = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_next = (~a_sr[0] & b_sr[0])
                    | (~(a_sr[0] ^ b_sr[0]) & brw);
    assign sh       = {d, res};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    // DONE accepts start too, so back-to-back
                    // operations skip the IDLE cycle.
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    res  <= sh[WIDTH-1:1];
                    brw  <= brw_next;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                        diff  <= sh;
                        bout  <= brw_next;
                        // d is the result MSB on this last bit.
                        ovf   <= (a_msb ^ b_msb) & (d ^ a_msb);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4).
// Vector table plus scoreboard queue; hand sequences for corner cases.
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    vec_t tv[10];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: diff=%0h no result pending",
                         diff);
            end else begin
                e = q.pop_front();
                chk("diff", 32'(diff), 32'(e.diff));
                chk("bout", 32'(bout), 32'(e.bout));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic start_op(input vec_t v, input bit push);
        exp_t e;
        @(negedge clk);
        a     = v.a;
        b     = v.b;
        bin   = v.bin;
        start = 1'b1;
        if (push) begin
            e.diff = v.diff;
            e.bout = v.bout;
            e.ovf  = v.ovf;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_capture", 32'(busy), 32'd1);
    endtask

    // Counts edges until done; expects done after exp_lat edges with
    // busy held on every sample before that.
    task automatic wait_done(input int exp_lat);
        int lat;
        int bcyc;
        bit seen;
        lat  = 0;
        bcyc = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1;
            else if (busy) bcyc++;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done, expected after %0d",
                     exp_lat);
        end else begin
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("busy_cycles", 32'(bcyc), 32'(exp_lat - 1));
        end
    endtask

    initial begin
        vec_t v;
        int   dc;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   dc;

        tv[0] = '{4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0};
        tv[1] = '{4'b0010, 4'b0110, 1'b0, 4'b1100, 1'b1, 1'b0};
        tv[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
        tv[3] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
        tv[4] = '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1};
        tv[5] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0};
        tv[6] = '{4'b0000, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0};
        tv[7] = '{4'b1111, 4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0};
        tv[8] = '{4'b0100, 4'b1100, 1'b0, 4'b1000, 1'b1, 1'b1};
        tv[9] = '{4'b1011, 4'b0010, 1'b1, 4'b1000, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            start_op(tv[i], 1'b1);
            wait_done(W);
            @(posedge clk);
            #1;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("hold_diff", 32'(diff), 32'(tv[i].diff));
        end

        // start during SHIFT is ignored; inputs wiggle after capture
        dc = done_cnt;
        v  = '{4'b1001, 4'b0110, 1'b0, 4'b0011, 1'b0, 1'b1};
        start_op(v, 1'b1);
        @(posedge clk);
        #1;
        a     = 4'b1111;
        b     = 4'b0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 4'b0101;
        b     = 4'b1010;
        bin   = 1'b1;
        wait_done(W - 2);
        repeat (8) @(posedge clk);
        #1;
        chk("single_done", 32'(done_cnt - dc), 32'd1);
        chk("no_requeue_busy", 32'(busy), 32'd0);

        // reset mid-operation aborts with no done
        v = '{4'b1100, 4'b0101, 1'b0, 4'b0111, 1'b0, 1'b1};
        start_op(v, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        dc = done_cnt;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        start_op(v, 1'b1);
        wait_done(W);
        @(posedge clk);

        // back-to-back: start held through the DONE cycle
        start_op(tv[0], 1'b1);
        wait_done(W);
        begin
            exp_t e;
            a      = 4'b1111;
            b      = 4'b1110;
            bin    = 1'b1;
            start  = 1'b1;
            e.diff = 4'b0000;
            e.bout = 1'b0;
            e.ovf  = 1'b0;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done", 32'(done), 32'd0);
        chk("b2b_hold_diff", 32'(diff), 32'(tv[0].diff));
        wait_done(W);
        repeat (3) @(posedge clk);
        #1;

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
